dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: port 0 (CPU
//  load/store path) and port 1 (program loader / debug access). Round-robin
//  arbitration, optional bounded burst lock, one-cycle synchronous read return.
//  Sits between the requesters and the data memory ports (addr/wenable/wvalue/rvalue).
// PARAMETERS
//  ADDR_WIDTH  8  data memory address width
//  DATA_WIDTH  8  data memory word width
//  MAX_BURST   4  max consecutive locked grants while the other port waits (>=1)
// PORTS
//  clock        in   1           rising-edge clock
//  nreset       in   1           reset; synchronous, active-low
//  m0_req       in   1           port 0 access request (level, held until granted)
//  m0_we        in   1           port 0: 1=write, 0=read
//  m0_lock      in   1           port 0 asks to keep ownership next cycle
//  m0_addr      in   ADDR_WIDTH  port 0 address
//  m0_wdata     in   DATA_WIDTH  port 0 write data
//  m0_gnt       out  1           port 0 access issued this cycle
//  m0_rvalid    out  1           port 0 read data valid (cycle after read grant)
//  m0_rdata     out  DATA_WIDTH  port 0 read data
//  m1_*         (same seven signals for port 1)
//  mem_addr     out  ADDR_WIDTH  memory address
//  mem_wenable  out  1           memory write enable
//  mem_wvalue   out  DATA_WIDTH  memory write data
//  mem_rvalue   in   DATA_WIDTH  memory read data, valid 1 cycle after address
// BEHAVIOUR
//  - State: owner in {IDLE, OWN0, OWN1}; last (last granted port); burst_cnt
//    (granted cycles in current ownership, saturates at MAX_BURST-1).
//  - Reset (nreset=0 at posedge): owner=IDLE, last=1 (port 0 wins first tie),
//    burst_cnt=0, m0/m1_rvalid=0, m0/m1_rdata=0. Grants are combinational from
//    registered state + reqs, so with nreset low gnt/wenable are forced 0.
//  - Grant decision per cycle (combinational):
//    * Owner k keeps grant if mk_req && (mk_lock || !other_req) &&
//      !(other_req && burst_cnt==MAX_BURST-1).
//    * Else if exactly one req: grant it. Both req: grant port != last.
//    * No req: no grant.
//  - At most one of m0_gnt/m1_gnt high per cycle. Granted port drives
//    mem_addr/mem_wvalue; mem_wenable = gnt && we. No grant: addr=0,
//    wvalue=0, wenable=0.
//  - Posedge update: granted port k -> last=k; owner=OWNk if mk_lock else IDLE;
//    burst_cnt = (same owner as before ? min(cnt+1,MAX_BURST-1) : 0).
//    No grant -> owner=IDLE, burst_cnt=0.
//  - Read return: read granted in cycle t -> mk_rvalid=1 in t+1 only,
//    mk_rdata=mem_rvalue sampled in t+1 (mux registered from grant). rdata holds
//    last value otherwise. Writes produce no rvalid.
//  - Back-to-back reads to alternating ports are allowed: one access per cycle,
//    full throughput, returns in grant order.
//  - Lock with MAX_BURST=1: lock never blocks a waiting other port.
//  - Lock dropped or req dropped: ownership released that same cycle decision.
//  - Reset mid-read: rvalid for the outstanding read is suppressed.
// TESTING
//  1 Reset: nreset=0 two cycles, both req -> no gnt, wenable=0, rvalid=0;
//    release with both req -> m0_gnt first, then m1_gnt (round-robin).
//  2 Write/read: m0 write addr 0x10 data 0xA5, then m1 read 0x10 ->
//    m1_rvalid one cycle after m1_gnt with m1_rdata=0xA5, m0_rvalid stays 0.
//  3 Burst lock: MAX_BURST=4, m1 locks reading 0x00..0x07, m0 req from cycle 1
//    -> m1 granted 4 cycles, m0 granted cycle 5, then alternation.
//  4 Lock uncontended: m0 lock with m1 idle -> m0 granted every cycle, no gap.
//  5 Tie alternation: both req continuously 8 cycles -> gnt strictly
//    alternates 0,1,0,1...; every read returns to the correct port.
//  6 Reset mid-read: m0 read granted, nreset=0 next cycle -> m0_rvalid=0,
//    owner IDLE, next tie after release granted to port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous data memory.
// Supports a bounded burst lock and returns read data one cycle after the grant.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wenable,
    output logic [DATA_WIDTH-1:0] mem_wvalue,
    input  logic [DATA_WIDTH-1:0] mem_rvalue
);

    localparam int               CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

    owner_t                owner, owner_next;
    logic                  last, last_next;
    logic [CNT_W-1:0]      burst_cnt, burst_next;
    logic                  gnt0, gnt1;
    logic                  keep0, keep1, at_limit;
    logic                  pend0, pend1;
    logic [DATA_WIDTH-1:0] hold0, hold1;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            owner     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
        end else begin
            owner     <= owner_next;
            last      <= last_next;
            burst_cnt <= burst_next;
        end
    end

    always_comb begin
        at_limit   = (burst_cnt == CNT_MAX);
        keep0      = (owner == OWN0) && m0_req && (m0_lock || !m1_req) && !(m1_req && at_limit);
        keep1      = (owner == OWN1) && m1_req && (m1_lock || !m0_req) && !(m0_req && at_limit);
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        owner_next = IDLE;
        last_next  = last;
        burst_next = '0;

        // Grants are held off entirely while reset is asserted.
        if (nreset) begin
            if (keep0) begin
                gnt0 = 1'b1;
            end else if (keep1) begin
                gnt1 = 1'b1;
            end else if (m0_req && m1_req) begin
                gnt0 = last;
                gnt1 = !last;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end

        if (gnt0) begin
            last_next = 1'b0;
            if (m0_lock) owner_next = OWN0;
            if (owner == OWN0) burst_next = at_limit ? burst_cnt : burst_cnt + CNT_W'(1);
        end else if (gnt1) begin
            last_next = 1'b1;
            if (m1_lock) owner_next = OWN1;
            if (owner == OWN1) burst_next = at_limit ? burst_cnt : burst_cnt + CNT_W'(1);
        end
    end

    assign m0_gnt      = gnt0;
    assign m1_gnt      = gnt1;
    assign mem_addr    = gnt0 ? m0_addr  : (gnt1 ? m1_addr  : '0);
    assign mem_wvalue  = gnt0 ? m0_wdata : (gnt1 ? m1_wdata : '0);
    assign mem_wenable = (gnt0 && m0_we) || (gnt1 && m1_we);

    always_ff @(posedge clock) begin
        if (!nreset) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            pend0 <= gnt0 && !m0_we;
            pend1 <= gnt1 && !m1_we;
            if (pend0) hold0 <= mem_rvalue;
            if (pend1) hold1 <= mem_rvalue;
        end
    end

    // Return path is steered by the registered grant; reset also masks an in-flight return.
    assign m0_rvalid = pend0 && nreset;
    assign m1_rvalid = pend1 && nreset;
    assign m0_rdata  = m0_rvalid ? mem_rvalue : hold0;
    assign m1_rdata  = m1_rvalid ? mem_rvalue : hold1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table plus randomized traffic checked against
// a transaction-level model; a second instance runs with MAX_BURST=1.
module tb_dmem_arbiter;

    typedef struct {
        bit       nr;
        bit       r0, w0, l0;
        bit [7:0] a0, d0;
        bit       r1, w1, l1;
        bit [7:0] a1, d1;
        bit       e_g0, e_g1, e_rv0, e_rv1;
        bit [7:0] e_rd;
    } vec_t;

    typedef struct {
        int       port;
        bit [7:0] data;
    } ret_t;

    logic       clock = 1'b0;
    logic       nreset = 1'b0;
    logic       m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
    logic [7:0] m0_addr = '0, m0_wdata = '0;
    logic       m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [7:0] m1_addr = '0, m1_wdata = '0;

    logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_wenable;
    logic [7:0] m0_rdata, m1_rdata, mem_addr, mem_wvalue;
    logic [7:0] mem_rvalue;

    logic       b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_wenable;
    logic [7:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wvalue;
    logic [7:0] b_rvalue = 8'h3C;

    logic [7:0] ram [256];
    logic       ram_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state, index 0 = main instance (burst 4), 1 = burst-1 instance
    int       own [2] = '{-1, -1};
    int       lst [2] = '{1, 1};
    int       cnt [2] = '{0, 0};
    int       mbv [2] = '{4, 1};
    bit [7:0] ref_mem [256];
    ret_t     rq [$];
    bit [7:0] held [2] = '{8'h00, 8'h00};
    int       b_pend = -1;
    bit [7:0] b_held [2] = '{8'h00, 8'h00};

    vec_t tv [$];

    dmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_BURST(4)) u_dut (
        .clock(clock), .nreset(nreset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wenable(mem_wenable), .mem_wvalue(mem_wvalue),
        .mem_rvalue(mem_rvalue)
    );

    dmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_BURST(1)) u_dut_b1 (
        .clock(clock), .nreset(nreset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .mem_addr(b_mem_addr), .mem_wenable(b_mem_wenable), .mem_wvalue(b_mem_wvalue),
        .mem_rvalue(b_rvalue)
    );

    always #5 clock = ~clock;

    // Single-port synchronous RAM, read-first, contents preloaded on the first edge
    always @(posedge clock) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 7 + 3);
            mem_rvalue <= '0;
            ram_ready  <= 1'b1;
        end else begin
            if (mem_wenable) ram[mem_addr] <= mem_wvalue;
            mem_rvalue <= ram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit nr,
                                input bit r0, input bit w0, input bit l0,
                                input bit [7:0] a0, input bit [7:0] d0,
                                input bit r1, input bit w1, input bit l1,
                                input bit [7:0] a1, input bit [7:0] d1,
                                input bit g0, input bit g1, input bit rv0, input bit rv1,
                                input bit [7:0] rd);
        vec_t v;
        v.nr = nr; v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.e_g0 = g0; v.e_g1 = g1; v.e_rv0 = rv0; v.e_rv1 = rv1; v.e_rd = rd;
        return v;
    endfunction

    // Which port the rules pick this cycle, or -1 for none
    function automatic int decide(input int s, input vec_t v);
        bit req [2];
        bit lk  [2];
        int k, o;
        req[0] = v.r0; req[1] = v.r1;
        lk[0]  = v.l0; lk[1]  = v.l1;
        if (!v.nr) return -1;
        if (own[s] >= 0) begin
            k = own[s];
            o = 1 - k;
            if (req[k] && (lk[k] || !req[o]) && !(req[o] && cnt[s] == mbv[s] - 1)) return k;
        end
        if (req[0] && req[1]) return 1 - lst[s];
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    function automatic void advance(input int s, input int g, input vec_t v);
        int nxt;
        if (!v.nr) begin
            own[s] = -1; lst[s] = 1; cnt[s] = 0;
        end else if (g >= 0) begin
            nxt    = (cnt[s] + 1 > mbv[s] - 1) ? mbv[s] - 1 : cnt[s] + 1;
            cnt[s] = (own[s] == g) ? nxt : 0;
            own[s] = ((g == 0) ? v.l0 : v.l1) ? g : -1;
            lst[s] = g;
        end else begin
            own[s] = -1; cnt[s] = 0;
        end
    endfunction

    task automatic step(input vec_t v, input bit tab);
        int       ga, gb, rport;
        bit       has, bw, ew0, ew1;
        bit [7:0] ea, ed, rdat;

        @(negedge clock);
        nreset  = v.nr;
        m0_req  = v.r0; m0_we = v.w0; m0_lock = v.l0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req  = v.r1; m1_we = v.w1; m1_lock = v.l1; m1_addr = v.a1; m1_wdata = v.d1;
        #1;

        ga   = decide(0, v);
        ea   = (ga == 0) ? v.a0 : ((ga == 1) ? v.a1 : 8'h00);
        ed   = (ga == 0) ? v.d0 : ((ga == 1) ? v.d1 : 8'h00);
        bw   = (ga == 0) ? v.w0 : ((ga == 1) ? v.w1 : 1'b0);
        has  = v.nr && (rq.size() > 0);
        rport = has ? rq[0].port : -1;
        rdat  = has ? rq[0].data : 8'h00;
        chk("gnt0", m0_gnt, ga == 0);
        chk("gnt1", m1_gnt, ga == 1);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wvalue", mem_wvalue, ed);
        chk("mem_wenable", mem_wenable, bw);
        chk("rvalid0", m0_rvalid, rport == 0);
        chk("rvalid1", m1_rvalid, rport == 1);
        chk("rdata0", m0_rdata, (rport == 0) ? rdat : held[0]);
        chk("rdata1", m1_rdata, (rport == 1) ? rdat : held[1]);

        if (tab) begin
            chk("tab_gnt0", m0_gnt, v.e_g0);
            chk("tab_gnt1", m1_gnt, v.e_g1);
            chk("tab_rvalid0", m0_rvalid, v.e_rv0);
            chk("tab_rvalid1", m1_rvalid, v.e_rv1);
            if (v.e_rv0) chk("tab_rdata0", m0_rdata, v.e_rd);
            if (v.e_rv1) chk("tab_rdata1", m1_rdata, v.e_rd);
        end

        gb  = decide(1, v);
        ew0 = v.nr && b_pend == 0;
        ew1 = v.nr && b_pend == 1;
        chk("b1_gnt0", b_m0_gnt, gb == 0);
        chk("b1_gnt1", b_m1_gnt, gb == 1);
        chk("b1_mem_addr", b_mem_addr, (gb == 0) ? v.a0 : ((gb == 1) ? v.a1 : 8'h00));
        chk("b1_mem_wenable", b_mem_wenable, (gb == 0) ? v.w0 : ((gb == 1) ? v.w1 : 1'b0));
        chk("b1_mem_wvalue", b_mem_wvalue, (gb == 0) ? v.d0 : ((gb == 1) ? v.d1 : 8'h00));
        chk("b1_rvalid0", b_m0_rvalid, ew0);
        chk("b1_rvalid1", b_m1_rvalid, ew1);
        chk("b1_rdata0", b_m0_rdata, ew0 ? 8'h3C : b_held[0]);
        chk("b1_rdata1", b_m1_rdata, ew1 ? 8'h3C : b_held[1]);

        @(posedge clock);
        if (!v.nr) begin
            rq.delete();
            held   = '{8'h00, 8'h00};
            b_pend = -1;
            b_held = '{8'h00, 8'h00};
        end else begin
            if (has) begin
                held[rport] = rdat;
                void'(rq.pop_front());
            end
            if (ga >= 0) begin
                if (bw) ref_mem[ea] = ed;
                else    rq.push_back('{ga, ref_mem[ea]});
            end
            if (b_pend >= 0) b_held[b_pend] = 8'h3C;
            b_pend = (gb >= 0 && !((gb == 0) ? v.w0 : v.w1)) ? gb : -1;
        end
        advance(0, ga, v);
        advance(1, gb, v);
        cyc++;
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);

        // reset with both requesting, then round-robin release
        tv.push_back(mk(0, 1,0,0,8'h00,8'h00, 1,0,0,8'h00,8'h00, 0,0,0,0,8'h00));
        tv.push_back(mk(0, 1,0,0,8'h00,8'h00, 1,0,0,8'h00,8'h00, 0,0,0,0,8'h00));
        tv.push_back(mk(1, 1,0,0,8'h20,8'h00, 1,0,0,8'h21,8'h00, 1,0,0,0,8'h00));
        tv.push_back(mk(1, 0,0,0,8'h00,8'h00, 1,0,0,8'h21,8'h00, 0,1,1,0,8'hE3));
        // write from port 0, read back through port 1
        tv.push_back(mk(1, 1,1,0,8'h10,8'hA5, 0,0,0,8'h00,8'h00, 1,0,0,1,8'hEA));
        tv.push_back(mk(1, 0,0,0,8'h00,8'h00, 1,0,0,8'h10,8'h00, 0,1,0,0,8'h00));
        tv.push_back(mk(1, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,1,8'hA5));
        tv.push_back(mk(1, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,8'h00));
        // uncontended lock on port 0
        tv.push_back(mk(1, 1,0,1,8'h30,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,0,8'h00));
        tv.push_back(mk(1, 1,0,1,8'h31,8'h00, 0,0,0,8'h00,8'h00, 1,0,1,0,8'h53));
        tv.push_back(mk(1, 1,0,1,8'h32,8'h00, 0,0,0,8'h00,8'h00, 1,0,1,0,8'h5A));
        tv.push_back(mk(1, 1,0,0,8'h33,8'h00, 0,0,0,8'h00,8'h00, 1,0,1,0,8'h61));
        tv.push_back(mk(1, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,1,0,8'h68));
        // port 1 burst lock capped at four grants while port 0 waits
        tv.push_back(mk(1, 0,0,0,8'h00,8'h00, 1,0,1,8'h00,8'h00, 0,1,0,0,8'h00));
        tv.push_back(mk(1, 1,0,0,8'h40,8'h00, 1,0,1,8'h01,8'h00, 0,1,0,1,8'h03));
        tv.push_back(mk(1, 1,0,0,8'h40,8'h00, 1,0,1,8'h02,8'h00, 0,1,0,1,8'h0A));
        tv.push_back(mk(1, 1,0,0,8'h40,8'h00, 1,0,1,8'h03,8'h00, 0,1,0,1,8'h11));
        tv.push_back(mk(1, 1,0,0,8'h40,8'h00, 1,0,1,8'h04,8'h00, 1,0,0,1,8'h18));
        tv.push_back(mk(1, 0,0,0,8'h00,8'h00, 1,0,1,8'h04,8'h00, 0,1,1,0,8'hC3));
        tv.push_back(mk(1, 1,0,0,8'h41,8'h00, 1,0,0,8'h05,8'h00, 1,0,0,1,8'h1F));
        tv.push_back(mk(1, 1,0,0,8'h42,8'h00, 1,0,0,8'h05,8'h00, 0,1,1,0,8'hCA));
        // continuous tie: strict alternation
        tv.push_back(mk(1, 1,0,0,8'h50,8'h00, 1,0,0,8'h60,8'h00, 1,0,0,1,8'h26));
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) tv.push_back(mk(1, 1,0,0,8'h50,8'h00, 1,0,0,8'h60,8'h00, 0,1,1,0,8'h33));
            else            tv.push_back(mk(1, 1,0,0,8'h50,8'h00, 1,0,0,8'h60,8'h00, 1,0,0,1,8'hA3));
        end
        // reset while a port 0 read is in flight
        tv.push_back(mk(1, 1,0,0,8'h70,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,1,8'hA3));
        tv.push_back(mk(0, 1,0,0,8'h70,8'h00, 1,0,0,8'h71,8'h00, 0,0,0,0,8'h00));
        tv.push_back(mk(1, 1,0,0,8'h70,8'h00, 1,0,0,8'h71,8'h00, 1,0,0,0,8'h00));
        tv.push_back(mk(1, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,1,0,8'h13));

        foreach (tv[i]) step(tv[i], 1'b1);

        for (int n = 0; n < 600; n++) begin
            v = mk(($urandom_range(0, 39) != 0),
                   ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 15)), 8'($urandom),
                   ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 15)), 8'($urandom),
                   0, 0, 0, 0, 8'h00);
            step(v, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
